// File: rtl/bias_memory_bank_pkg.sv
// rtl/bias_memory_bank_pkg.sv - load FSM states, default sizes and address-width helper for bias_memory_bank
package bias_memory_bank_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } bias_state_t;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bias_mem_array.sv
// rtl/bias_mem_array.sv - one DEPTH x DATA_W bank, synchronous write, registered read (zero when not reading)
module bias_mem_array
    import bias_memory_bank_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking write above gives read-before-write on a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= re ? mem[raddr] : '0;
        end
    end

endmodule

// File: rtl/bias_memory_bank.sv
// rtl/bias_memory_bank.sv - layer bias store with streamed load, registered read, address-error flag; BIAS_MEM_PINGPONG_EN adds a shadow bank
module bias_memory_bank
    import bias_memory_bank_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              loaded,
    output logic [ADDR_W-1:0] ld_count,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              addr_err,
    input  logic              err_clr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    bias_state_t       state, state_nxt;
    logic [ADDR_W-1:0] count_q;
    logic              accept;
    logic              rd_in, wr_in, rd_ok, wr_ok, any_err;

    assign rd_in    = 32'(rd_addr) < 32'(DEPTH);
    assign wr_in    = 32'(wr_addr) < 32'(DEPTH);
    assign rd_ok    = rd && rd_in;
    assign wr_ok    = we && wr_in && (state == ST_IDLE);
    assign any_err  = (rd && !rd_in) || (we && !wr_in);
    assign ld_count = count_q;

    // A restart in LOAD takes priority over the word offered that cycle.
    always_comb begin
        state_nxt = state;
        ld_ready  = 1'b0;
        accept    = 1'b0;
        ld_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ld_start) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (!ld_start && ld_valid) begin
                    accept = 1'b1;
                    if (count_q == LAST) begin
                        ld_done   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            count_q  <= '0;
            loaded   <= 1'b0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            rd_valid <= rd;
            if (ld_start) begin
                count_q <= '0;
            end else if (accept) begin
                count_q <= ld_done ? '0 : count_q + 1'b1;
            end
`ifndef BIAS_MEM_PINGPONG_EN
            if (state == ST_IDLE && ld_start) begin
                loaded <= 1'b0;
            end
`endif
            if (ld_done) begin
                loaded <= 1'b1;
            end
            if (any_err) begin
                addr_err <= 1'b1;
            end else if (err_clr) begin
                addr_err <= 1'b0;
            end
        end
    end

`ifdef BIAS_MEM_PINGPONG_EN
    logic              bank_sel;
    logic [DATA_W-1:0] bank_rdata [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_sel <= 1'b0;
        end else if (ld_done) begin
            bank_sel <= ~bank_sel;
        end
    end

    // Only the active bank is read, so the idle bank's read register holds zero and an OR selects.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam logic ME = (b == 1);
        logic ld_here, wr_here;
        assign ld_here = accept && (bank_sel != ME);
        assign wr_here = wr_ok && (bank_sel == ME);
        bias_mem_array #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (ld_here || wr_here),
            .waddr (ld_here ? count_q : wr_addr),
            .wdata (ld_here ? ld_data : wr_data),
            .re    (rd_ok && (bank_sel == ME)),
            .raddr (rd_addr),
            .rdata (bank_rdata[b])
        );
    end

    assign rd_data = bank_rdata[0] | bank_rdata[1];
`else
    bias_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (accept || wr_ok),
        .waddr (accept ? count_q : wr_addr),
        .wdata (accept ? ld_data : wr_data),
        .re    (rd_ok),
        .raddr (rd_addr),
        .rdata (rd_data)
    );
`endif

endmodule

// File: tb/tb_bias_memory_bank.sv
// tb/tb_bias_memory_bank.sv - self-checking bench for bias_memory_bank (optionally with BIAS_MEM_PINGPONG_EN)
module tb_bias_memory_bank;

    localparam int DW    = 16;
    localparam int DEPTH = 10;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ld_start = 1'b0, ld_valid = 1'b0;
    logic [DW-1:0] ld_data = '0;
    logic          ld_ready, ld_done, loaded;
    logic [AW-1:0] ld_count;
    logic          we = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid, addr_err;
    logic          err_clr = 1'b0;

    bias_memory_bank #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_done(ld_done), .loaded(loaded), .ld_count(ld_count),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd(rd), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .addr_err(addr_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [DW-1:0] model [DEPTH];
    logic          merr = 1'b0;
    bit            ever_loaded = 1'b0;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          rd;
        logic [AW-1:0] ra;
        logic          clr;
        logic [DW-1:0] ed;
        logic          ev;
        logic          ee;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        merr = 1'b0;
        ever_loaded = 1'b0;
    endtask

    task automatic read_chk(input logic [AW-1:0] a);
        rd = 1'b1; rd_addr = a;
        @(posedge clk); #1;
        chk("readback_valid", rd_valid, 1'b1);
        chk("readback_data", rd_data, model[a]);
        rd = 1'b0;
    endtask

    // gap_mode: 0 continuous, 1 every other cycle, 2 random; stop_after < 0 runs the full load
    task automatic do_load(input logic [DW-1:0] base, input int gap_mode, input bit rd_watch, input int stop_after);
        int            k = 0;
        int            cyc = 0;
        bit            done = 1'b0;
        logic          v;
        logic [DW-1:0] old0 = model[0];
        logic [DW-1:0] fresh [DEPTH];
        ld_start = 1'b1;
        @(posedge clk); #1;
        ld_start = 1'b0;
        chk("ld_ready_in_load", ld_ready, 1'b1);
`ifdef BIAS_MEM_PINGPONG_EN
        chk("loaded_through_reload", loaded, ever_loaded);
`else
        chk("loaded_cleared_on_load", loaded, 1'b0);
`endif
        while (!done && cyc < 200 && k != stop_after) begin
            v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            ld_valid = v; ld_data = base + DW'(k);
            rd = rd_watch; rd_addr = '0;
            @(negedge clk);
            chk("ld_count_step", ld_count, k);
            chk("ld_done_pulse", ld_done, (v && k == DEPTH - 1));
            @(posedge clk); #1;
            if (rd_watch) chk("pingpong_old_read", rd_data, old0);
            if (v) begin
                fresh[k] = base + DW'(k);
                k++;
                if (k == DEPTH) done = 1'b1;
            end
            cyc++;
        end
        ld_valid = 1'b0; rd = 1'b0;
        if (stop_after < 0 && !done) chk("load_timeout", 0, 1);
        if (done) begin
            for (int i = 0; i < DEPTH; i++) model[i] = fresh[i];
            ever_loaded = 1'b1;
            chk("loaded_after_done", loaded, 1'b1);
            chk("ld_ready_after_done", ld_ready, 1'b0);
            chk("ld_count_after_done", ld_count, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd12, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[1]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  1'b1, 16'h0000, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 4'd15, 16'h1234, 1'b0, 4'd0,  1'b1, 16'h0000, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  1'b1, 16'h0000, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 4'd2,  16'hFFF6, 1'b1, 4'd2,  1'b0, 16'h0102, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd2,  1'b0, 16'hFFF6, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd0,  1'b0, 16'h0100, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd9,  1'b0, 16'h0109, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd9,  1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 4'd9,  16'h8000, 1'b0, 4'd0,  1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd9,  1'b0, 16'h8000, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd10, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  1'b1, 16'h0000, 1'b0, 1'b0};

        do_reset();
        chk("rst_ld_ready", ld_ready, 1'b0);
        chk("rst_ld_done", ld_done, 1'b0);
        chk("rst_loaded", loaded, 1'b0);
        chk("rst_ld_count", ld_count, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_addr_err", addr_err, 1'b0);

        do_load(16'h0001, 0, 1'b0, -1);
        rd = 1'b1; rd_addr = 4'd3;
        @(posedge clk); #1;
        chk("t1_rd_valid", rd_valid, 1'b1);
        chk("t1_rd_data", rd_data, 16'h0004);
        rd = 1'b0;
        @(posedge clk); #1;
        chk("t1_idle_valid", rd_valid, 1'b0);
        chk("t1_idle_data", rd_data, 16'h0000);

        do_load(16'h0100, 1, 1'b0, -1);
        for (int a = 0; a < DEPTH; a++) read_chk(AW'(a));

        for (int i = 0; i < 13; i++) begin
            we = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
            rd = tbl[i].rd; rd_addr = tbl[i].ra; err_clr = tbl[i].clr;
            @(posedge clk); #1;
            if (tbl[i].we && tbl[i].wa < DEPTH) model[tbl[i].wa] = tbl[i].wd;
            chk($sformatf("tbl%0d_rd_data", i), rd_data, tbl[i].ed);
            chk($sformatf("tbl%0d_rd_valid", i), rd_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_addr_err", i), addr_err, tbl[i].ee);
        end
        we = 1'b0; rd = 1'b0; err_clr = 1'b0;

        do_load(16'h0300, 0, 1'b0, 5);
        rst = 1'b1;
        #1;
        chk("midrst_loaded", loaded, 1'b0);
        chk("midrst_ld_ready", ld_ready, 1'b0);
        chk("midrst_ld_count", ld_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        merr = 1'b0;
        ever_loaded = 1'b0;
        do_load(16'h0200, 2, 1'b0, -1);
        for (int a = 0; a < DEPTH; a++) read_chk(AW'(a));

`ifdef BIAS_MEM_PINGPONG_EN
        do_load(16'h0001, 0, 1'b0, -1);
        do_load(16'h0100, 0, 1'b1, -1);
        rd = 1'b1; rd_addr = '0;
        @(posedge clk); #1;
        chk("pingpong_new_read", rd_data, 16'h0100);
        rd = 1'b0;
`endif

        for (int i = 0; i < 400; i++) begin
            logic [DW-1:0] exp_d;
            logic          exp_v;
            if (i % 100 == 50) begin
                we = 1'b0; rd = 1'b0; err_clr = 1'b0;
                do_load(DW'($urandom), 2, 1'b0, -1);
            end
            rd      = 1'($urandom_range(0, 1));
            rd_addr = AW'($urandom_range(0, 15));
            we      = ($urandom_range(0, 3) == 0);
            wr_addr = AW'($urandom_range(0, 11));
            wr_data = DW'($urandom);
            err_clr = ($urandom_range(0, 7) == 0);
            exp_v = rd;
            exp_d = (rd && rd_addr < DEPTH) ? model[rd_addr] : '0;
            if ((rd && rd_addr >= DEPTH) || (we && wr_addr >= DEPTH)) merr = 1'b1;
            else if (err_clr) merr = 1'b0;
            if (we && wr_addr < DEPTH) model[wr_addr] = wr_data;
            @(posedge clk); #1;
            chk("rand_rd_data", rd_data, exp_d);
            chk("rand_rd_valid", rd_valid, exp_v);
            chk("rand_addr_err", addr_err, merr);
        end
        we = 1'b0; rd = 1'b0; err_clr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
